// File: rtl/snake_sprite_compositor.sv
// Snake game state and two-stage sprite compositor.
// Stage 1 finds the lowest-index segment under the current pixel and
// addresses the sprite ROM; stage 2 merges ROM data with the background
// through the colour key.
module snake_sprite_compositor #(
    parameter int          SPRITE_SIZE  = 24,
    parameter int          NUM_SEGMENTS = 8,
    parameter int          INIT_LEN     = 3,
    parameter int          START_X      = 320,
    parameter int          START_Y      = 240,
    parameter int          H_ACTIVE     = 640,
    parameter int          V_ACTIVE     = 480,
    parameter logic [11:0] KEY_RGB      = 12'hF0F,
    localparam int         AW = $clog2(SPRITE_SIZE * SPRITE_SIZE),
    localparam int         LW = $clog2(NUM_SEGMENTS + 1)
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic [7:0]    keycode,
    input  logic          move_tick,
    input  logic          grow,
    input  logic [9:0]    DrawX,
    input  logic [9:0]    DrawY,
    input  logic          blank,
    output logic [AW-1:0] spr_addr,
    output logic [1:0]    spr_sel,
    input  logic [11:0]   spr_rgb,
    input  logic [11:0]   bg_rgb,
    output logic [3:0]    red,
    output logic [3:0]    green,
    output logic [3:0]    blue,
    output logic [9:0]    head_x,
    output logic [9:0]    head_y,
    output logic [LW-1:0] length,
    output logic          self_hit
);

    typedef logic [9:0] coord_t;

    localparam logic signed [11:0] SS12  = 12'(SPRITE_SIZE);
    localparam logic signed [11:0] H12   = 12'(H_ACTIVE);
    localparam logic signed [11:0] V12   = 12'(V_ACTIVE);
    localparam logic signed [10:0] SS11  = 11'(SPRITE_SIZE);
    localparam logic signed [10:0] HALF11 = 11'(SPRITE_SIZE / 2);
    localparam logic [AW-1:0]      SS_A  = AW'(SPRITE_SIZE);
    localparam logic [LW-1:0]      NSEG  = LW'(NUM_SEGMENTS);
    localparam logic [LW-1:0]      ONE   = LW'(1);

    // Reset x position of segment i: trailing to the left of START_X, wrapped.
    function automatic coord_t init_x(int i);
        int v;
        v = (START_X - i * SPRITE_SIZE) % H_ACTIVE;
        if (v < 0) v = v + H_ACTIVE;
        return coord_t'(v);
    endfunction

    coord_t        seg_x [NUM_SEGMENTS];
    coord_t        seg_y [NUM_SEGMENTS];
    logic [1:0]    dir, pend_dir;
    logic          key_ok;
    logic [1:0]    key_dir;
    logic signed [11:0] nx, ny;
    coord_t        new_x, new_y;
    logic [LW-1:0] len_next;
    logic          collide;

    assign head_x   = seg_x[0];
    assign head_y   = seg_y[0];
    assign len_next = (grow && length < NSEG) ? length + ONE : length;

    // Map WASD scan codes onto the direction encoding shared with spr_sel.
    always_comb begin
        key_ok  = 1'b1;
        key_dir = 2'd3;
        case (keycode)
            8'h1A:   key_dir = 2'd0;
            8'h04:   key_dir = 2'd1;
            8'h16:   key_dir = 2'd2;
            8'h07:   key_dir = 2'd3;
            default: key_ok  = 1'b0;
        endcase
    end

    // Next head position one sprite step in pend_dir, wrapped into the playfield.
    always_comb begin
        nx = signed'({2'b00, seg_x[0]});
        ny = signed'({2'b00, seg_y[0]});
        case (pend_dir)
            2'd0:    ny = ny - SS12;
            2'd1:    nx = nx - SS12;
            2'd2:    ny = ny + SS12;
            default: nx = nx + SS12;
        endcase
        if (nx < 0)        nx = nx + H12;
        else if (nx >= H12) nx = nx - H12;
        if (ny < 0)        ny = ny + V12;
        else if (ny >= V12) ny = ny - V12;
        new_x = nx[9:0];
        new_y = ny[9:0];
    end

    // Post-move collision: new head against the shifted body (old seg[i-1]).
    always_comb begin
        collide = 1'b0;
        for (int i = 1; i < NUM_SEGMENTS; i++)
            if (LW'(i) < len_next && new_x == seg_x[i-1] && new_y == seg_y[i-1])
                collide = 1'b1;
    end

    // Snake state: direction latch, body shift on move, length, sticky collision.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < NUM_SEGMENTS; i++) begin
                seg_x[i] <= init_x(i);
                seg_y[i] <= coord_t'(START_Y);
            end
            dir      <= 2'd3;
            pend_dir <= 2'd3;
            length   <= LW'(INIT_LEN);
            self_hit <= 1'b0;
        end else begin
            // A straight reversal would fold the head into the neck, so drop it.
            if (key_ok && key_dir != (dir ^ 2'd2))
                pend_dir <= key_dir;
            if (move_tick) begin
                dir      <= pend_dir;
                seg_x[0] <= new_x;
                seg_y[0] <= new_y;
                for (int i = 1; i < NUM_SEGMENTS; i++) begin
                    seg_x[i] <= seg_x[i-1];
                    seg_y[i] <= seg_y[i-1];
                end
                if (collide) self_hit <= 1'b1;
            end
            length <= len_next;
        end
    end

    logic              hit_c;
    logic [AW-1:0]     addr_c;
    logic [1:0]        sel_c;
    logic signed [10:0] dxv, dyv;

    // Hit test over all active segments; walking high-to-low leaves the lowest hit.
    always_comb begin
        hit_c  = 1'b0;
        addr_c = '0;
        sel_c  = 2'd3;
        dxv    = '0;
        dyv    = '0;
        for (int i = NUM_SEGMENTS - 1; i >= 0; i--) begin
            dxv = signed'({1'b0, DrawX}) - signed'({1'b0, seg_x[i]}) + HALF11;
            dyv = signed'({1'b0, DrawY}) - signed'({1'b0, seg_y[i]}) + HALF11;
            if (LW'(i) < length && dxv >= 0 && dxv < SS11 && dyv >= 0 && dyv < SS11) begin
                hit_c  = 1'b1;
                addr_c = AW'(dyv) * SS_A + AW'(dxv);
                sel_c  = (i == 0) ? dir : 2'd3;
            end
        end
    end

    logic hit_q, blank_q;

    // Stage 1 registers: ROM address/select plus hit and blank delayed to meet ROM data.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            spr_addr <= '0;
            spr_sel  <= 2'd3;
            hit_q    <= 1'b0;
            blank_q  <= 1'b0;
        end else begin
            spr_addr <= addr_c;
            spr_sel  <= sel_c;
            hit_q    <= hit_c;
            blank_q  <= blank;
        end
    end

    // Stage 2: key out transparent sprite texels, black outside active video.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            {red, green, blue} <= 12'h000;
        else if (!blank_q)
            {red, green, blue} <= 12'h000;
        else if (hit_q && spr_rgb != KEY_RGB)
            {red, green, blue} <= spr_rgb;
        else
            {red, green, blue} <= bg_rgb;
    end

endmodule

// File: tb/tb_snake_sprite_compositor.sv
// Directed plus randomized bench for snake_sprite_compositor against a
// position-list model of the game rules and the sprite hit test.
module tb_snake_sprite_compositor;

    localparam int S = 24, HALF = 12, NS = 8, H = 640, V = 480;

    logic        Clk, Reset;
    logic [7:0]  keycode;
    logic        move_tick, grow;
    logic [9:0]  DrawX, DrawY;
    logic        blank;
    logic [9:0]  spr_addr;
    logic [1:0]  spr_sel;
    logic [11:0] spr_rgb, bg_rgb;
    logic [3:0]  red, green, blue;
    logic [9:0]  head_x, head_y;
    logic [3:0]  length;
    logic        self_hit;

    snake_sprite_compositor dut (
        .Clk(Clk), .Reset(Reset), .keycode(keycode), .move_tick(move_tick),
        .grow(grow), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
        .spr_addr(spr_addr), .spr_sel(spr_sel), .spr_rgb(spr_rgb),
        .bg_rgb(bg_rgb), .red(red), .green(green), .blue(blue),
        .head_x(head_x), .head_y(head_y), .length(length), .self_hit(self_hit)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int n_chk = 0, n_pass = 0, n_fail = 0;

    // Reference model: plain list of segment centres
    int mx[NS], my[NS];
    int mlen, mdir, mpend;
    bit mhit;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            mx[i] = ((320 - i * S) % H + H) % H;
            my[i] = 240;
        end
        mlen = 3; mdir = 3; mpend = 3; mhit = 0;
    endtask

    // One clock edge of game rules, using the inputs currently driven.
    task automatic model_edge();
        int kd, np, nx, ny;
        case (keycode)
            8'h1A: kd = 0;
            8'h04: kd = 1;
            8'h16: kd = 2;
            8'h07: kd = 3;
            default: kd = -1;
        endcase
        np = mpend;
        if (kd >= 0 && kd != (mdir + 2) % 4) np = kd;
        if (move_tick) begin
            nx = mx[0]; ny = my[0];
            case (mpend)
                0: ny -= S;
                1: nx -= S;
                2: ny += S;
                default: nx += S;
            endcase
            nx = (nx + H) % H;
            ny = (ny + V) % V;
            for (int i = NS - 1; i > 0; i--) begin mx[i] = mx[i-1]; my[i] = my[i-1]; end
            mx[0] = nx; my[0] = ny;
            mdir = mpend;
        end
        if (grow && mlen < NS) mlen++;
        if (move_tick)
            for (int i = 1; i < mlen; i++)
                if (mx[i] == mx[0] && my[i] == my[0]) mhit = 1;
        mpend = np;
    endtask

    task automatic tick();
        model_edge();
        @(posedge Clk);
        #1;
        move_tick = 0; grow = 0; keycode = 8'h00;
    endtask

    task automatic move();
        move_tick = 1;
        tick();
    endtask

    task automatic check_state(string tag);
        chk({tag, ".hx"},  head_x,   mx[0]);
        chk({tag, ".hy"},  head_y,   my[0]);
        chk({tag, ".len"}, length,   mlen);
        chk({tag, ".hit"}, self_hit, mhit);
    endtask

    function automatic int w11(int v);
        int r;
        r = v & 2047;
        if (r >= 1024) r -= 2048;
        return r;
    endfunction

    // Present one pixel, then the ROM/background data a cycle later, and check both stages.
    task automatic pix_check(string tag, int px, int py, bit blk, logic [11:0] srgb, logic [11:0] brgb);
        int dx, dy, ea, es;
        bit eh;
        logic [11:0] ergb;
        px = px & 1023; py = py & 1023;
        eh = 0; ea = 0; es = 3;
        for (int i = 0; i < mlen && !eh; i++) begin
            dx = w11(px - mx[i] + HALF);
            dy = w11(py - my[i] + HALF);
            if (dx >= 0 && dx < S && dy >= 0 && dy < S) begin
                eh = 1; ea = dy * S + dx; es = (i == 0) ? mdir : 3;
            end
        end
        DrawX = 10'(px); DrawY = 10'(py); blank = blk;
        tick();
        chk({tag, ".addr"}, spr_addr, ea);
        chk({tag, ".sel"},  spr_sel,  es);
        spr_rgb = srgb; bg_rgb = brgb;
        tick();
        ergb = !blk ? 12'h000 : (eh && srgb != 12'hF0F) ? srgb : brgb;
        chk({tag, ".rgb"}, {red, green, blue}, ergb);
    endtask

    task automatic do_reset();
        Reset = 1;
        repeat (2) @(posedge Clk);
        #1 Reset = 0;
        model_reset();
    endtask

    logic [7:0] keys [6];

    initial begin
        keys = '{8'h1A, 8'h04, 8'h16, 8'h07, 8'h55, 8'h00};
        keycode = 0; move_tick = 0; grow = 0; DrawX = 0; DrawY = 0;
        blank = 0; spr_rgb = 0; bg_rgb = 0; Reset = 0;

        // Reset state
        do_reset();
        chk("rst.rgb", {red, green, blue}, 12'h000);
        chk("rst.addr", spr_addr, 0);
        chk("rst.hit", self_hit, 0);
        chk("rst.len", length, 3);
        chk("rst.hx", head_x, 320);
        chk("rst.hy", head_y, 240);

        // Single move right; old head becomes seg[1]
        move();
        chk("mv1.hx", head_x, 344);
        chk("mv1.hy", head_y, 240);
        chk("mv1.len", length, 3);
        pix_check("mv1.seg1", 320, 240, 1, 12'hABC, 12'h123);

        // Reverse key ignored, then turn up
        keycode = 8'h04; tick();
        move();
        chk("rev.hx", head_x, 368);
        keycode = 8'h1A; tick();
        move();
        chk("up.hy", head_y, 216);
        chk("up.hx", head_x, 368);

        // Head centre pixel: key colour, opaque colour, blanking
        pix_check("head.key", 368, 216, 1, 12'hF0F, 12'h123);
        chk("head.key.c", {red, green, blue}, 12'h123);
        pix_check("head.opq", 368, 216, 1, 12'hABC, 12'h123);
        chk("head.opq.c", {red, green, blue}, 12'hABC);
        pix_check("head.blk", 368, 216, 0, 12'hABC, 12'h123);
        chk("head.blk.c", {red, green, blue}, 12'h000);
        pix_check("edge.in", 368 - HALF, 216 + HALF - 1, 1, 12'h456, 12'h789);
        pix_check("edge.out", 368 + HALF, 216, 1, 12'h456, 12'h789);

        // Horizontal and vertical wrap
        keycode = 8'h07; tick();
        for (int k = 0; k < 11; k++) begin move(); check_state("wrx"); end
        chk("wrx.632", head_x, 632);
        move();
        chk("wrx.16", head_x, 16);
        keycode = 8'h1A; tick();
        for (int k = 0; k < 9; k++) begin move(); check_state("wry"); end
        chk("wry.0", head_y, 0);
        move();
        chk("wry.456", head_y, 456);

        // Grow with saturation; first pulse coincides with a move
        do_reset();
        grow = 1; move_tick = 1; tick();
        chk("grw.len4", length, 4);
        for (int k = 0; k < 6; k++) begin grow = 1; tick(); end
        chk("grw.sat", length, 8);
        check_state("grw");
        pix_check("grw.tail", 272, 240, 1, 12'hABC, 12'h123);
        chk("grw.tail.sel", spr_sel, 3);
        chk("grw.tail.addr", spr_addr, 300);

        // Self collision: up, left, down with length 5
        do_reset();
        grow = 1; tick();
        grow = 1; tick();
        keycode = 8'h1A; tick(); move();
        keycode = 8'h04; tick(); move();
        chk("col.pre", self_hit, 0);
        keycode = 8'h16; tick(); move();
        chk("col.hit", self_hit, 1);
        move(); move();
        chk("col.sticky", self_hit, 1);
        check_state("col");

        // Asynchronous reset mid-cycle with a pending move and grow
        move_tick = 1; grow = 1;
        #2 Reset = 1;
        #1 chk("arst.hit", self_hit, 0);
        chk("arst.hx", head_x, 320);
        @(posedge Clk);
        #1 Reset = 0; move_tick = 0; grow = 0;
        model_reset();
        check_state("arst");

        // Randomized play with periodic pixel probes
        for (int c = 0; c < 300; c++) begin
            keycode   = keys[$urandom_range(0, 5)];
            move_tick = ($urandom_range(0, 2) == 0);
            grow      = ($urandom_range(0, 7) == 0);
            tick();
            check_state("rnd");
            if (c % 10 == 9) begin
                int k;
                k = $urandom_range(0, NS - 1);
                pix_check("rndpix", mx[k] + $urandom_range(0, 29) - 14,
                          my[k] + $urandom_range(0, 29) - 14, ($urandom_range(0, 5) != 0),
                          ($urandom_range(0, 2) == 0) ? 12'hF0F : 12'($urandom),
                          12'($urandom));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/snake_sprite_compositor.md
SNAKE_SPRITE_COMPOSITOR -- requirements
Module: snake_sprite_compositor

Interface
REQ-001 Parameter SPRITE_SIZE, default 24: sprite edge in pixels; must be even; HALF = SPRITE_SIZE/2.
REQ-002 Parameter NUM_SEGMENTS, default 8: maximum snake segments, head included.
REQ-003 Parameter INIT_LEN, default 3: length after reset, 1..NUM_SEGMENTS.
REQ-004 Parameter START_X / START_Y, default 320 / 240: head centre after reset.
REQ-005 Parameter H_ACTIVE / V_ACTIVE, default 640 / 480: playfield size used for wrap-around.
REQ-006 Parameter KEY_RGB, default 12'hF0F: transparent colour key as {R,G,B}.
REQ-007 Ports: Clk input 1: pixel clock, the only clock.
REQ-008 Ports: Reset input 1: asynchronous, active-high.
REQ-009 Ports: keycode input 8: 8'h1A=W (up), 8'h04=A (left), 8'h16=S (down), 8'h07=D (right); any other code is ignored.
REQ-010 Ports: move_tick input 1: one-cycle pulse that advances the snake one step; grow input 1: one-cycle pulse that adds one segment.
REQ-011 Ports: DrawX, DrawY input 10: current pixel; blank input 1: 1 = active video.
REQ-012 Ports: spr_addr output clog2(SPRITE_SIZE^2): sprite ROM address; spr_sel output 2: 0 up-head, 1 left-head, 2 down-head, 3 body.
REQ-013 Ports: spr_rgb input 12: ROM data valid 1 cycle after spr_addr; bg_rgb input 12: background pixel with the same 1-cycle alignment.
REQ-014 Ports: red, green, blue output 4 each, registered pixel colour.
REQ-015 Ports: head_x, head_y output 10; length output clog2(NUM_SEGMENTS+1); self_hit output 1.

Function
REQ-016 Direction register dir uses the spr_sel encoding; on reset dir = 3 (right), pend_dir = 3.
REQ-017 A valid keycode loads pend_dir on the next edge, unless it is the exact reverse of dir; a reverse keycode leaves pend_dir unchanged.
REQ-018 On move_tick, dir <= pend_dir and seg[0] moves SPRITE_SIZE pixels in pend_dir; seg[i] <= old seg[i-1] for i>=1, all in the same edge.
REQ-019 Wrap-around: x < 0 maps to x+H_ACTIVE and x >= H_ACTIVE maps to x-H_ACTIVE; y wraps the same way with V_ACTIVE; head coordinates stay in range at all times.
REQ-020 grow sets length <= length+1, saturating at NUM_SEGMENTS; grow and move_tick in the same cycle both take effect, and the new segment takes the old tail position.
REQ-021 After each move, self_hit is set if seg[0] equals any seg[i] with 1 <= i < length; self_hit is sticky until Reset; movement continues after self_hit is set.
REQ-022 A keycode and a move_tick in the same cycle: the move uses the pend_dir held before that edge, and the keycode applies to the next move.
REQ-023 Stage 1 (registered): for each active segment, dx = DrawX - segx + HALF and dy = DrawY - segy + HALF, computed signed at 11 bits; the pixel hits the segment when 0 <= dx,dy < SPRITE_SIZE.
REQ-024 Priority goes to the lowest hit index; spr_addr = dy*SPRITE_SIZE + dx of that segment; spr_sel = dir for index 0, otherwise 3.
REQ-025 With no hit, spr_addr = 0, spr_sel = 3, and the hit flag is 0.
REQ-026 Stage 2 (registered): if blank = 0, output 0; else if the delayed hit flag is set and spr_rgb != KEY_RGB, output spr_rgb; otherwise output bg_rgb.
REQ-027 Latency: DrawX/DrawY to red/green/blue is exactly 2 Clk cycles; blank is delayed to match.
REQ-028 Segments with index >= length never hit, hold their positions, and still shift on move_tick.

Reset
REQ-029 Reset asynchronously clears red/green/blue, spr_addr, pipeline flags and self_hit to 0.
REQ-030 Reset sets length = INIT_LEN, seg[i] = (START_X - i*SPRITE_SIZE wrapped, START_Y), and dir = pend_dir = 3.
REQ-031 Asserting Reset mid-frame or mid-move discards any pending move or grow; normal operation resumes on the first edge after deassertion.

Verification
REQ-032 Reset, then a single move_tick -> head_x = 344, head_y = 240, seg[1] = (320,240), length = 3.
REQ-033 keycode 8'h04 while dir = right, then move_tick -> no direction change, head_x advances by 24; keycode 8'h1A, then move_tick -> head_y = 216.
REQ-034 Head at x = 632 heading right, then move_tick -> head_x = 16; head at y = 0 heading up, then move_tick -> head_y = 456.
REQ-035 grow pulsed 7 times from reset, including one pulse coincident with a move_tick -> length = 8, saturated; old tail position retained as seg[3].
REQ-036 Pixel at the head centre with blank = 1, spr_rgb = 12'hF0F, bg_rgb = 12'h123 -> output 1,2,3 two cycles later; spr_rgb = 12'hABC -> A,B,C; blank = 0 -> 0,0,0.
REQ-037 Drive the sequence up, left, down (each followed by move_tick) with length >= 5 -> self_hit = 1 after the colliding move and remains 1 until Reset.
